// File: rtl/toggle_cover_collector.sv
`default_nettype none
// ============================================================================
// toggle_cover_collector: sticky toggle-coverage bitmap with popcount and
// streamed readout. Optional TOGGLE_COVER_CLEAR_ON_READ_EN clears words as read.
// Revision: 1.0
// ============================================================================
module toggle_cover_collector #(
    parameter int COVER_TOTAL = 8744,
    parameter int WORDS       = (COVER_TOTAL + 31) / 32,
    parameter int IDX_W       = (WORDS > 1) ? $clog2(WORDS) : 1
) (
    input  logic             gbl_clk,
    input  logic             reset,
    input  logic             hit_valid,
    input  logic [IDX_W-1:0] hit_widx,
    input  logic [31:0]      hit_bits,
    input  logic             dump_req,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [IDX_W-1:0] out_widx,
    output logic             out_last,
    output logic             busy,
    output logic [15:0]      covered_cnt,
    output logic             err_oor
);

    localparam int               c_tail      = COVER_TOTAL % 32;
    localparam logic [31:0]      c_tail_mask = (c_tail == 0) ? 32'hFFFF_FFFF
                                                             : ((32'h1 << c_tail) - 32'h1);
    localparam logic [IDX_W-1:0] c_last_idx  = IDX_W'(WORDS - 1);
    localparam logic [IDX_W:0]   c_words     = (IDX_W + 1)'(WORDS);
`ifdef TOGGLE_COVER_CLEAR_ON_READ_EN
    localparam logic             c_clear_on_read = 1'b1;
`else
    localparam logic             c_clear_on_read = 1'b0;
`endif

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DUMP = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [5:0] popcnt32(input logic [31:0] v);
        logic [5:0] n;
        n = 6'd0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

    logic [31:0]      r_bitmap [WORDS];
    state_t           r_state;
    logic             r_out_valid;
    logic [IDX_W-1:0] r_out_widx;
    logic             r_out_last;
    logic             r_busy;
    logic [15:0]      r_covered_cnt;
    logic             r_err_oor;

    logic             w_in_range;
    logic             w_rec;
    logic [IDX_W-1:0] w_rec_idx;
    logic [31:0]      w_hit_mask;
    logic             w_xfer;
    logic             w_clr;
    logic             w_same;
    logic [31:0]      w_rec_old;
    logic [31:0]      w_rec_new;
    logic [5:0]       w_add;
    logic [5:0]       w_sub;
    logic [IDX_W-1:0] w_next_widx;

    assign w_in_range  = ({1'b0, hit_widx} < c_words);
    assign w_rec       = hit_valid & w_in_range;
    assign w_rec_idx   = w_in_range ? hit_widx : '0;
    assign w_hit_mask  = hit_bits & ((hit_widx == c_last_idx) ? c_tail_mask : 32'hFFFF_FFFF);
    assign w_xfer      = r_out_valid & out_ready;
    assign w_clr       = c_clear_on_read & w_xfer;
    assign w_same      = w_rec & (hit_widx == r_out_widx);
    assign w_next_widx = r_out_widx + 1'b1;

    // A word cleared by readout in the same cycle it is hit keeps only the new hits.
    always_comb begin
        w_rec_old = r_bitmap[w_rec_idx];
        if (w_clr && w_same) begin
            w_rec_old = 32'h0;
        end
        w_rec_new = w_rec_old | w_hit_mask;
        w_add     = w_rec ? popcnt32(w_hit_mask & ~w_rec_old) : 6'd0;
        w_sub     = w_clr ? popcnt32(r_bitmap[r_out_widx]) : 6'd0;
    end

    always_ff @(posedge gbl_clk) begin
        if (!reset) begin
            for (int i = 0; i < WORDS; i++) begin
                r_bitmap[i] <= 32'h0;
            end
        end else begin
            if (w_clr) begin
                r_bitmap[r_out_widx] <= 32'h0;
            end
            if (w_rec) begin
                r_bitmap[hit_widx] <= w_rec_new;
            end
        end
    end

    always_ff @(posedge gbl_clk) begin
        if (!reset) begin
            r_covered_cnt <= 16'd0;
            r_err_oor     <= 1'b0;
        end else begin
            r_covered_cnt <= r_covered_cnt + {10'd0, w_add} - {10'd0, w_sub};
            if (hit_valid && !w_in_range) begin
                r_err_oor <= 1'b1;
            end
        end
    end

    always_ff @(posedge gbl_clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_out_valid <= 1'b0;
            r_out_widx  <= '0;
            r_out_last  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (dump_req) begin
                        r_state     <= DUMP;
                        r_out_valid <= 1'b1;
                        r_out_widx  <= '0;
                        r_out_last  <= (c_last_idx == '0);
                        r_busy      <= 1'b1;
                    end
                end
                DUMP: begin
                    if (w_xfer) begin
                        if (r_out_last) begin
                            r_state     <= DONE;
                            r_out_valid <= 1'b0;
                            r_out_last  <= 1'b0;
                            r_out_widx  <= '0;
                        end else begin
                            r_out_widx  <= w_next_widx;
                            r_out_last  <= (w_next_widx == c_last_idx);
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state     <= IDLE;
                    r_out_valid <= 1'b0;
                    r_out_last  <= 1'b0;
                    r_busy      <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid   = r_out_valid;
    assign out_widx    = r_out_widx;
    assign out_last    = r_out_last;
    assign out_data    = r_bitmap[r_out_widx];
    assign busy        = r_busy;
    assign covered_cnt = r_covered_cnt;
    assign err_oor     = r_err_oor;

endmodule
`default_nettype wire

// File: tb/tb_toggle_cover_collector.sv
`default_nettype none
// ============================================================================
// tb_toggle_cover_collector: randomized bench against a word-array coverage model.
// Revision: 1.0
// ============================================================================
module tb_toggle_cover_collector;

    localparam int COVER_TOTAL = 8744;
    localparam int WORDS       = 274;
    localparam int IDX_W       = 9;

    logic             gbl_clk;
    logic             reset;
    logic             hit_valid;
    logic [IDX_W-1:0] hit_widx;
    logic [31:0]      hit_bits;
    logic             dump_req;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic [IDX_W-1:0] out_widx;
    logic             out_last;
    logic             busy;
    logic [15:0]      covered_cnt;
    logic             err_oor;

    toggle_cover_collector #(
        .COVER_TOTAL(COVER_TOTAL),
        .WORDS      (WORDS),
        .IDX_W      (IDX_W)
    ) u_dut (
        .gbl_clk    (gbl_clk),
        .reset      (reset),
        .hit_valid  (hit_valid),
        .hit_widx   (hit_widx),
        .hit_bits   (hit_bits),
        .dump_req   (dump_req),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_widx   (out_widx),
        .out_last   (out_last),
        .busy       (busy),
        .covered_cnt(covered_cnt),
        .err_oor    (err_oor)
    );

    initial gbl_clk = 1'b0;
    always #5 gbl_clk = ~gbl_clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] mem [WORDS];
    bit          m_dump;
    bit          m_done;
    bit          m_err;
    int          m_idx;
    int          xfers;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic int model_cnt();
        int n = 0;
        for (int i = 0; i < WORDS; i++) n += $countones(mem[i]);
        return n;
    endfunction

    function automatic logic [31:0] mask_of(input int w);
        logic [31:0] m = 32'hFFFF_FFFF;
        if (w == WORDS - 1 && (COVER_TOTAL % 32) != 0) m = (32'h1 << (COVER_TOTAL % 32)) - 1;
        return m;
    endfunction

    task automatic compare_all();
        chk("out_valid", {31'd0, out_valid}, {31'd0, m_dump});
        chk("busy", {31'd0, busy}, {31'd0, (m_dump || m_done)});
        chk("covered_cnt", {16'd0, covered_cnt}, model_cnt());
        chk("err_oor", {31'd0, err_oor}, {31'd0, m_err});
        if (m_dump) begin
            chk("out_widx", {23'd0, out_widx}, m_idx);
            chk("out_data", out_data, mem[m_idx]);
            chk("out_last", {31'd0, out_last}, {31'd0, (m_idx == WORDS - 1)});
        end else begin
            chk("out_last_idle", {31'd0, out_last}, 32'd0);
        end
    endtask

    // One clock: apply the inputs held now, then advance the model by the same rules.
    task automatic tick();
        logic             r  = reset;
        logic             hv = hit_valid;
        int               hw = int'(hit_widx);
        logic [31:0]      hb = hit_bits;
        logic             dr = dump_req;
        logic             rd = out_ready;
        bit               xfer;
        @(posedge gbl_clk);
        #1;
        if (!r) begin
            for (int i = 0; i < WORDS; i++) mem[i] = 32'h0;
            m_dump = 0; m_done = 0; m_idx = 0; m_err = 0;
        end else begin
            xfer = m_dump && rd;
            if (xfer) xfers++;
`ifdef TOGGLE_COVER_CLEAR_ON_READ_EN
            if (xfer) mem[m_idx] = 32'h0;
`endif
            if (hv) begin
                if (hw < WORDS) mem[hw] = mem[hw] | (hb & mask_of(hw));
                else m_err = 1;
            end
            if (m_done) m_done = 0;
            else if (m_dump) begin
                if (xfer) begin
                    if (m_idx == WORDS - 1) begin m_dump = 0; m_done = 1; end
                    else m_idx++;
                end
            end else if (dr) begin
                m_dump = 1; m_idx = 0;
            end
        end
        compare_all();
    endtask

    task automatic do_hit(input int w, input logic [31:0] b);
        hit_valid = 1'b1; hit_widx = IDX_W'(w); hit_bits = b;
        tick();
        hit_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        reset = 1'b1;
    endtask

    initial begin
        int cyc;
        reset = 1'b0; hit_valid = 1'b0; hit_widx = '0; hit_bits = '0;
        dump_req = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < WORDS; i++) mem[i] = 32'h0;
        m_dump = 0; m_done = 0; m_err = 0; m_idx = 0; xfers = 0;
        tick(); tick();
        reset = 1'b1;
        chk("reset_cnt", {16'd0, covered_cnt}, 32'd0);
        chk("reset_busy", {31'd0, busy}, 32'd0);

        do_hit(0, 32'h5);
        chk("first_hit_cnt", {16'd0, covered_cnt}, 32'd2);
        do_hit(0, 32'h5);
        chk("repeat_hit_cnt", {16'd0, covered_cnt}, 32'd2);

        do_reset();
        do_hit(273, 32'hFFFF_FFFF);
        chk("last_word_cnt", {16'd0, covered_cnt}, 32'd8);
        do_hit(300, 32'hFFFF_FFFF);
        chk("oor_err", {31'd0, err_oor}, 32'd1);
        chk("oor_cnt", {16'd0, covered_cnt}, 32'd8);
        tick(); tick();
        chk("oor_sticky", {31'd0, err_oor}, 32'd1);

        // Full readout with out_ready alternating.
        do_hit(5, 32'hA5A5_A5A5);
        dump_req = 1'b1; tick(); dump_req = 1'b0;
        xfers = 0; out_ready = 1'b0; cyc = 0;
        while ((m_dump || m_done) && cyc < 2000) begin
            out_ready = ~out_ready;
            if (m_dump && m_idx == 5)   chk("dump_idx5", out_data, 32'hA5A5_A5A5);
            if (m_dump && m_idx == 273) chk("dump_idx273", out_data, 32'h0000_00FF);
            tick();
            cyc++;
        end
        out_ready = 1'b0;
        chk("dump_xfers", xfers, WORDS);
        chk("dump_end_busy", {31'd0, busy}, 32'd0);

        // Abort a dump by reset at index 100; a second dump_req mid-dump is ignored.
        do_hit(7, 32'h3);
        dump_req = 1'b1; tick(); dump_req = 1'b0;
        out_ready = 1'b1; cyc = 0;
        while (m_dump && m_idx < 100 && cyc < 500) begin
            dump_req = (m_idx == 50);
            tick();
            cyc++;
        end
        dump_req = 1'b0;
        chk("abort_at_100", m_idx, 100);
        do_reset();
        chk("abort_valid", {31'd0, out_valid}, 32'd0);
        chk("abort_cnt", {16'd0, covered_cnt}, 32'd0);
        tick();
        chk("abort_valid2", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b0;

`ifdef TOGGLE_COVER_CLEAR_ON_READ_EN
        do_reset();
        do_hit(5, 32'h2);
        dump_req = 1'b1; tick(); dump_req = 1'b0;
        out_ready = 1'b1; cyc = 0;
        while (m_dump && m_idx < 5 && cyc < 100) begin tick(); cyc++; end
        chk("cor_old", out_data, 32'h2);
        do_hit(5, 32'h1);
        chk("cor_cnt", {16'd0, covered_cnt}, 32'd1);
        cyc = 0;
        while ((m_dump || m_done) && cyc < 500) begin tick(); cyc++; end
        out_ready = 1'b0;
        chk("cor_cnt_end", {16'd0, covered_cnt}, 32'd1);
`endif

        // Randomized traffic: sparse hits, stray indices, dumps, stalls, rare resets.
        for (int n = 0; n < 3000; n++) begin
            hit_valid = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 15) == 0)     hit_widx = IDX_W'($urandom_range(WORDS, 511));
            else if (m_dump && $urandom_range(0, 3) == 0) hit_widx = IDX_W'(m_idx);
            else if ($urandom_range(0, 7) == 0) hit_widx = IDX_W'(WORDS - 1);
            else                                hit_widx = IDX_W'($urandom_range(0, WORDS - 1));
            hit_bits  = $urandom & $urandom & $urandom;
            dump_req  = ($urandom_range(0, 40) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            reset     = ($urandom_range(0, 800) != 0);
            tick();
        end
        hit_valid = 1'b0; dump_req = 1'b0; reset = 1'b1; out_ready = 1'b1;
        cyc = 0;
        while ((m_dump || m_done) && cyc < 1000) begin tick(); cyc++; end
        dump_req = 1'b1; tick(); dump_req = 1'b0;
        cyc = 0;
        while ((m_dump || m_done) && cyc < 1000) begin tick(); cyc++; end
        chk("final_idle", {31'd0, busy}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
